hazard_forward_unit: RTL

- Produces the forwardA/forwardB operand-select codes consumed by the execute stage, plus load-use stall and branch-flush controls for the 5-stage RISC-V pipeline.
- Keeps its own shadow scoreboard of destination-register info for the EX, MEM and WB stages, advanced in lockstep with the pipeline registers.
- Forward codes are registered on the ID->EX transition, so they are stable for the whole cycle the instruction spends in EX.

---
 rtl/hazard_forward_unit_pkg.sv | 13 +
 rtl/hazard_forward_unit_slot.sv | 38 +++
 rtl/hazard_forward_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the hazard/forwarding unit: operand-select encodings
// (these must match the execute stage's operand mux case values) and the default register width.
package hazard_forward_unit_pkg;

   localparam int REG_NUM_BITWIDTH = 5;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_MEMWB = 2'b01,
      FWD_EXMEM = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/hazard_forward_unit_slot.sv
// One shadow-scoreboard slot holding {valid, rd, regwrite, memread} for a pipeline stage.
// An invalid slot always holds zeroed fields, so stale rd values cannot match anything.
module hazard_slot #(
   parameter int REG_NUM_BITWIDTH = 5
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        bubble,
   input  logic                        d_valid,
   input  logic [REG_NUM_BITWIDTH-1:0] d_rd,
   input  logic                        d_regwrite,
   input  logic                        d_memread,
   output logic                        q_valid,
   output logic [REG_NUM_BITWIDTH-1:0] q_rd,
   output logic                        q_regwrite,
   output logic                        q_memread
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_valid    <= 1'b0;
         q_rd       <= '0;
         q_regwrite <= 1'b0;
         q_memread  <= 1'b0;
      end else if (bubble || !d_valid) begin
         q_valid    <= 1'b0;
         q_rd       <= '0;
         q_regwrite <= 1'b0;
         q_memread  <= 1'b0;
      end else begin
         q_valid    <= 1'b1;
         q_rd       <= d_rd;
         q_regwrite <= d_regwrite;
         q_memread  <= d_memread;
      end
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding, load-use stall and branch-flush control for the 5-stage pipeline.
// Tracks EX/MEM/WB destination info in shadow slots; forward codes are registered on ID->EX.
module hazard_forward_unit
   import hazard_forward_unit_pkg::*;
#(
   parameter int REG_NUM_BITWIDTH = 5,
   parameter int CNT_WIDTH        = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        id_valid,
   input  logic [REG_NUM_BITWIDTH-1:0] id_rs1,
   input  logic [REG_NUM_BITWIDTH-1:0] id_rs2,
   input  logic                        id_uses_rs1,
   input  logic                        id_uses_rs2,
   input  logic [REG_NUM_BITWIDTH-1:0] id_rd,
   input  logic                        id_regwrite,
   input  logic                        id_memread,
   input  logic                        ex_branch_taken,
   output logic [1:0]                  forwardA,
   output logic [1:0]                  forwardB,
   output logic                        stall_if,
   output logic                        bubble_ex,
   output logic                        flush_id,
   output logic [CNT_WIDTH-1:0]        stall_count,
   output logic [CNT_WIDTH-1:0]        flush_count
);

   logic                        ex_valid, ex_regwrite, ex_memread;
   logic [REG_NUM_BITWIDTH-1:0] ex_rd;
   logic                        mem_valid, mem_regwrite, mem_memread;
   logic [REG_NUM_BITWIDTH-1:0] mem_rd;
   logic                        wb_valid, wb_regwrite, wb_memread;
   logic [REG_NUM_BITWIDTH-1:0] wb_rd;

   logic     load_use;
   fwd_sel_e fwd_a_nxt, fwd_b_nxt;
   fwd_sel_e fwd_a_q, fwd_b_q;
   logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

   hazard_slot #(.REG_NUM_BITWIDTH(REG_NUM_BITWIDTH)) u_slot_ex (
      .clk        (clk),
      .rst_n      (rst_n),
      .bubble     (bubble_ex),
      .d_valid    (id_valid),
      .d_rd       (id_rd),
      .d_regwrite (id_regwrite),
      .d_memread  (id_memread),
      .q_valid    (ex_valid),
      .q_rd       (ex_rd),
      .q_regwrite (ex_regwrite),
      .q_memread  (ex_memread)
   );

   hazard_slot #(.REG_NUM_BITWIDTH(REG_NUM_BITWIDTH)) u_slot_mem (
      .clk        (clk),
      .rst_n      (rst_n),
      .bubble     (1'b0),
      .d_valid    (ex_valid),
      .d_rd       (ex_rd),
      .d_regwrite (ex_regwrite),
      .d_memread  (ex_memread),
      .q_valid    (mem_valid),
      .q_rd       (mem_rd),
      .q_regwrite (mem_regwrite),
      .q_memread  (mem_memread)
   );

   hazard_slot #(.REG_NUM_BITWIDTH(REG_NUM_BITWIDTH)) u_slot_wb (
      .clk        (clk),
      .rst_n      (rst_n),
      .bubble     (1'b0),
      .d_valid    (mem_valid),
      .d_rd       (mem_rd),
      .d_regwrite (mem_regwrite),
      .d_memread  (mem_memread),
      .q_valid    (wb_valid),
      .q_rd       (wb_rd),
      .q_regwrite (wb_regwrite),
      .q_memread  (wb_memread)
   );

   always_comb begin
      load_use = 1'b0;
      if (id_valid && ex_valid && ex_memread && ex_regwrite && (ex_rd != '0)) begin
         load_use = (id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd));
      end
   end

   // Flush wins: the ID instruction is being discarded, so its stall is moot.
   always_comb begin
      flush_id  = ex_branch_taken;
      bubble_ex = ex_branch_taken || load_use;
      stall_if  = !ex_branch_taken && load_use;
   end

   // WB is deliberately not a source: the register file is write-first.
   always_comb begin
      fwd_a_nxt = FWD_RF;
      fwd_b_nxt = FWD_RF;
      if (id_uses_rs1 && (id_rs1 != '0)) begin
         if (ex_valid && ex_regwrite && (ex_rd == id_rs1))
            fwd_a_nxt = FWD_EXMEM;
         else if (mem_valid && mem_regwrite && (mem_rd == id_rs1))
            fwd_a_nxt = FWD_MEMWB;
      end
      if (id_uses_rs2 && (id_rs2 != '0)) begin
         if (ex_valid && ex_regwrite && (ex_rd == id_rs2))
            fwd_b_nxt = FWD_EXMEM;
         else if (mem_valid && mem_regwrite && (mem_rd == id_rs2))
            fwd_b_nxt = FWD_MEMWB;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_a_q <= FWD_RF;
         fwd_b_q <= FWD_RF;
      end else if (bubble_ex || !id_valid) begin
         fwd_a_q <= FWD_RF;
         fwd_b_q <= FWD_RF;
      end else begin
         fwd_a_q <= fwd_a_nxt;
         fwd_b_q <= fwd_b_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_if && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 1'b1;
         if (flush_id && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   // The WB slot is never a forward source; it only has to stay self-consistent.
   wb_slot_clean : assert property (@(posedge clk) disable iff (!rst_n)
      !wb_valid |-> ((wb_rd == '0) && !wb_regwrite && !wb_memread));

   assign forwardA    = fwd_a_q;
   assign forwardB    = fwd_b_q;
   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule
